// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_PASS_S = 4'b0000;
  localparam logic [3:0] ALU_PASS_R = 4'b0001;
  localparam logic [3:0] ALU_INC    = 4'b0010;
  localparam logic [3:0] ALU_DEC    = 4'b0011;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_ADC    = 4'b0110;
  localparam logic [3:0] ALU_SBC    = 4'b0111;
  localparam logic [3:0] ALU_AND    = 4'b1000;
  localparam logic [3:0] ALU_OR     = 4'b1001;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_NOT    = 4'b1011;
  localparam logic [3:0] ALU_NEG    = 4'b1100;
  localparam logic [3:0] ALU_SHL    = 4'b1101;
  localparam logic [3:0] ALU_SHR    = 4'b1110;
  localparam logic [3:0] ALU_ASR    = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEGA  = 3'd1,
    NEGB  = 3'd2,
    ITER  = 3'd3,
    FIXLO = 3'd4,
    FIXHI = 3'd5,
    DONE  = 3'd6
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16->32 multiply sequencer driving the shared ALU, one ALU op per clock.
// Define ALU_MUL_SEQ_SIGNED_EN to enable signed multiply (sgn input, NEGA/NEGB/FIXLO/FIXHI).
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         alu_op,
  output logic [WIDTH-1:0]   alu_r,
  output logic [WIDTH-1:0]   alu_s,
  input  logic [WIDTH-1:0]   alu_y,
  input  logic               alu_c,
  input  logic               alu_z
);

  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  mul_state_t         state_reg, state_next;
  logic [WIDTH-1:0]   m_reg, m_next;
  logic [WIDTH-1:0]   ph_reg, ph_next;
  logic [WIDTH-1:0]   pl_reg, pl_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] product_reg;

`ifdef ALU_MUL_SEQ_SIGNED_EN
  // sgnop marks a signed request so ITER exits through the fix-up states.
  logic sign_reg, sign_next;
  logic zlo_reg, zlo_next;
  logic sgnop_reg, sgnop_next;
`else
  logic unused_in;
  assign unused_in = ^{sgn, alu_z};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      m_reg       <= '0;
      ph_reg      <= '0;
      pl_reg      <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      sign_reg    <= 1'b0;
      zlo_reg     <= 1'b0;
      sgnop_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      ph_reg    <= ph_next;
      pl_reg    <= pl_next;
      cnt_reg   <= cnt_next;
      // Capture the final register values on the same edge that enters DONE.
      if (state_next == DONE && state_reg != DONE)
        product_reg <= {ph_next, pl_next};
`ifdef ALU_MUL_SEQ_SIGNED_EN
      sign_reg  <= sign_next;
      zlo_reg   <= zlo_next;
      sgnop_reg <= sgnop_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    ph_next    = ph_reg;
    pl_next    = pl_reg;
    cnt_next   = cnt_reg;
    alu_op     = ALU_PASS_S;
    alu_r      = '0;
    alu_s      = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    sign_next  = sign_reg;
    zlo_next   = zlo_reg;
    sgnop_next = sgnop_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next     = a;
          pl_next    = b;
          ph_next    = '0;
          cnt_next   = '0;
          state_next = ITER;
`ifdef ALU_MUL_SEQ_SIGNED_EN
          sgnop_next = sgn;
          sign_next  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          if (sgn) state_next = NEGA;
`endif
        end
      end

`ifdef ALU_MUL_SEQ_SIGNED_EN
      NEGA: begin
        alu_s      = m_reg;
        alu_op     = m_reg[WIDTH-1] ? ALU_NEG : ALU_PASS_S;
        m_next     = alu_y;
        state_next = NEGB;
      end

      NEGB: begin
        alu_s      = pl_reg;
        alu_op     = pl_reg[WIDTH-1] ? ALU_NEG : ALU_PASS_S;
        pl_next    = alu_y;
        state_next = ITER;
      end
`endif

      ITER: begin
        // The ALU carry becomes the new top bit, so 0x8000 magnitudes stay exact.
        alu_op   = pl_reg[0] ? ALU_ADD : ALU_PASS_R;
        alu_r    = ph_reg;
        alu_s    = m_reg;
        ph_next  = {alu_c, alu_y[WIDTH-1:1]};
        pl_next  = {alu_y[0], pl_reg[WIDTH-1:1]};
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
`ifdef ALU_MUL_SEQ_SIGNED_EN
          if (sgnop_reg) state_next = FIXLO;
`endif
        end
      end

`ifdef ALU_MUL_SEQ_SIGNED_EN
      FIXLO: begin
        alu_s      = pl_reg;
        alu_op     = sign_reg ? ALU_NEG : ALU_PASS_S;
        pl_next    = alu_y;
        zlo_next   = alu_z;
        state_next = FIXHI;
      end

      FIXHI: begin
        // Two's-complement of the 32-bit value: the high half only takes the +1 carry when the low half is zero.
        alu_s      = ph_reg;
        alu_op     = !sign_reg ? ALU_PASS_S : (zlo_reg ? ALU_NEG : ALU_NOT);
        ph_next    = alu_y;
        state_next = DONE;
      end
`endif

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE) && (state_reg != DONE);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU, cycle-level reference model and directed vectors.
module tb_alu_mul_seq;

`ifdef ALU_MUL_SEQ_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;
  logic [3:0]  alu_op;
  logic [15:0] alu_r, alu_s, alu_y;
  logic        alu_c, alu_z;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_op(alu_op), .alu_r(alu_r), .alu_s(alu_s),
    .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z)
  );

  // Behavioural shared ALU as the parent datapath would provide it.
  always_comb begin
    logic [16:0] sum;
    sum   = {1'b0, alu_r} + {1'b0, alu_s};
    alu_y = 16'h0000;
    alu_c = 1'b0;
    case (alu_op)
      4'b0000: alu_y = alu_s;
      4'b0001: alu_y = alu_r;
      4'b0100: {alu_c, alu_y} = sum;
      4'b1011: alu_y = ~alu_s;
      4'b1100: alu_y = 16'h0000 - alu_s;
      default: alu_y = 16'h0000;
    endcase
    alu_z = (alu_y == 16'h0000);
  end

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [31:0] xe, ye;
    xe = {16'h0000, x};
    ye = {16'h0000, y};
    if (s && SGN_EN) begin
      xe = {{16{x[15]}}, x};
      ye = {{16{y[15]}}, y};
    end
    return xe * ye;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since the accepted start; done at t == lat.
  int          t = 0;
  int          lat = 17;
  logic [31:0] pend = '0;
  logic [31:0] exp_prod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t        <= 0;
      exp_prod <= '0;
    end else if (t == 0) begin
      if (start) begin
        t    <= 1;
        lat  <= (sgn && SGN_EN) ? 21 : 17;
        pend <= ref_mul(a, b, sgn);
      end
    end else if (t == lat) begin
      t <= 0;
    end else begin
      t <= t + 1;
      if (t + 1 == lat) exp_prod <= pend;
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("cyc_busy", 32'(busy), 32'((t >= 1) && (t < lat)));
      chk("cyc_done", 32'(done), 32'((t != 0) && (t == lat)));
      chk("cyc_product", product, exp_prod);
      if (t == 0) begin
        chk("idle_alu_op", 32'(alu_op), 32'h0);
        chk("idle_alu_rs", {alu_r, alu_s}, 32'h0);
      end
    end
  end

  task automatic run_mul(input logic [15:0] av, input logic [15:0] bv, input logic s,
                         input logic [31:0] exp_p, input int exp_lat, input string nm);
    int n, nb;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv; sgn = s;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'h1);
    chk({nm, "_product"}, product, exp_p);
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(exp_lat - 1));
    $display("txn %s: a=0x%04h b=0x%04h sgn=%0d product=0x%08h latency=%0d", nm, av, bv, s, product, n);
  endtask

  initial begin
    int n, dones;
    bit seen;
    reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_product", product, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_rs", {alu_r, alu_s}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    armed = 1'b1;

    run_mul(16'h0003, 16'h0005, 1'b0, 32'h0000000F, 17, "u_3x5");
    run_mul(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17, "u_ffff_sq");
    run_mul(16'h0000, 16'h1234, 1'b0, 32'h00000000, 17, "u_0x1234");
    run_mul(16'h1234, 16'h5678, 1'b0, 32'h06260060, 17, "u_1234x5678");

    // start held high throughout with changing operands: only the first request counts
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0007; b = 16'h0009; sgn = 1'b0;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("hold_done_seen", 32'(seen), 32'h1);
    chk("hold_product", product, 32'h0000003F);
    chk("hold_latency", 32'(n), 32'd17);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("hold_extra_dones", 32'(dones), 32'h0);
    $display("txn hold: a=0x0007 b=0x0009 product=0x%08h latency=%0d", product, n);

    // reset in cycle k+8 aborts the multiply and clears product
    @(posedge clk); #1;
    start = 1'b1; a = 16'h00FF; b = 16'h0101; sgn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_product", product, 32'h0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("abort_no_done", 32'(dones), 32'h0);
    $display("txn abort: a=0x00FF b=0x0101 product=0x%08h dones=%0d", product, dones);
    run_mul(16'h0002, 16'h0002, 1'b0, 32'h00000004, 17, "u_2x2_after_abort");

    // signed requests; without the signed build sgn is ignored
    run_mul(16'hFFFD, 16'h0005, 1'b1, SGN_EN ? 32'hFFFFFFF1 : 32'h0004FFF1, SGN_EN ? 21 : 17, "s_m3x5");
    run_mul(16'h8000, 16'h8000, 1'b1, 32'h40000000, SGN_EN ? 21 : 17, "s_8000sq");
    run_mul(16'hFFFF, 16'h0002, 1'b1, SGN_EN ? 32'hFFFFFFFE : 32'h0001FFFE, SGN_EN ? 21 : 17, "s_m1x2");
    run_mul(16'h0003, 16'hFFF9, 1'b1, SGN_EN ? 32'hFFFFFFEB : 32'h0002FFEB, SGN_EN ? 21 : 17, "s_3xm7");
    run_mul(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 17, "u_ffffx2");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16x16 -> 32-bit multiply sequencer that drives the shared 16-bit ALU with a shift-add algorithm, one ALU operation per clock. It sits beside the ALU in the processor datapath: the parent instantiates the ALU once and routes its R/S/op inputs from this block while a multiply is in progress. It has a start/busy/done handshake toward the control unit and a held 32-bit product.

## Interface
- WIDTH, 16, operand width; must equal ALU width; only 16 is supported.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sgn  in  1  1 = signed (two's-complement) multiply; honoured only with macro
- a  in  16  multiplicand, sampled with start
- b  in  16  multiplier, sampled with start
- busy  out  1  high in every non-IDLE, non-DONE state
- done  out  1  one-cycle pulse; product valid
- product  out  32  result; updates only on entry to DONE, held otherwise
- alu_op  out  4  ALU function select
- alu_r  out  16  ALU R operand
- alu_s  out  16  ALU S operand
- alu_y  in  16  ALU result
- alu_c  in  1  ALU carry
- alu_z  in  1  ALU zero flag

## Operation
- ALU op codes used: PASS_S 0000, PASS_R 0001, ADD 0100, NOT 1011, NEG 1100.
- Internal registers: M[15:0], PH[15:0], PL[15:0], cnt[3:0], sign, zlo.
- IDLE: alu_op=PASS_S, alu_r=0, alu_s=0. When start=1: M<=a, PL<=b, PH<=0, cnt<=0, sign<=a[15]^b[15] (0 unless signed). Next state is ITER (unsigned) or NEGA (signed).
- ITER: alu_op = PL[0] ? ADD : PASS_R; alu_r=PH; alu_s=M. Register update: PH<={alu_c, alu_y[15:1]}, PL<={alu_y[0], PL[15:1]}, cnt<=cnt+1. PASS_R yields C=0. After cnt=15 the next state is FIXLO (signed) or DONE.
- DONE: product<={PH,PL}, done=1 for one cycle, then IDLE. A start seen in DONE is ignored.
- A start in any state other than IDLE is ignored, with no queueing. a and b may change freely after the start cycle.
- Result is exact modulo 2^32. The unsigned result never overflows 32 bits.
- Reset values: state IDLE; busy 0; done 0; product 0; alu_op 0000; alu_r 0; alu_s 0; all internal registers 0.
- Reset asserted mid-operation aborts immediately. done is not asserted and product is cleared to 0.

## Timing
- start high at edge k -> busy high during cycles k+1..k+16 -> done high in cycle k+17 (unsigned).
- Signed: busy during k+1..k+20, done in cycle k+21.
- Latency is fixed and does not depend on the data.
- ALU outputs are combinational from state/registers. ALU results are registered at the end of the same cycle, so the ALU path must close in one cycle.
- Back-to-back: start may be re-asserted in the cycle after done, which is IDLE.

## Configuration
- ALU_MUL_SEQ_SIGNED_EN defined adds states NEGA, NEGB, FIXLO and FIXHI.
  - NEGA: alu_s=M, alu_op = M[15] ? NEG : PASS_S; M<=alu_y.
  - NEGB: same on PL.
  - FIXLO: alu_s=PL, alu_op = sign ? NEG : PASS_S; PL<=alu_y, zlo<=alu_z.
  - FIXHI: alu_s=PH, alu_op = !sign ? PASS_S : (zlo ? NEG : NOT); PH<=alu_y.
  - Taking all four states when sgn=1 keeps latency fixed. A magnitude of 0x8000 is handled correctly as unsigned 32768.
- Undefined: sgn is ignored, the four states are not compiled, and every request is unsigned.

## Structure
- Shared package alu_pkg holds the ALU op-code localparams (the five above plus the remaining codes) and the state enum (IDLE, NEGA, NEGB, ITER, FIXLO, FIXHI, DONE).
- No sub-module. The ALU is instanced by the parent and shared, so this block only contains the FSM, counter and shift registers.

## Test plan
- Unsigned 3 x 5, start at edge k -> done in cycle k+17, product=0x0000000F; busy high for exactly 16 cycles.
- Unsigned 0xFFFF x 0xFFFF -> product=0xFFFE0001. 0 x 0x1234 -> product=0x00000000.
- start held high during busy with new operands -> ignored; the first result is intact; one done pulse only.
- reset pulsed in cycle k+8 of 0x00FF x 0x0101 -> IDLE next cycle, product=0, no done. A fresh 2 x 2 afterwards gives 4.
- With the macro: sgn=1, 0xFFFD x 0x0005 -> product=0xFFFFFFF1 at k+21. 0x8000 x 0x8000 -> 0x40000000.
- Without the macro: sgn=1, 0xFFFF x 0x0002 -> product=0x0001FFFE at k+17.
